// File: rtl/noc_node_adapter_pkg.sv
// Shared definitions for the mesh endpoint adapter.
//   MESH_SIDE   : mesh side length (nodes per row/column)
//   COORD_W     : coordinate width, DELTA_W : signed delta width
//   FLIT_DATA_W : payload width carried by the shared flit typedefs
//   dir_e       : router port directions
//   tx_flit_t / rx_flit_t : flit layouts held in the TX and RX FIFOs
package noc_node_adapter_pkg;

    localparam int unsigned MESH_SIDE   = 4;
    localparam int unsigned COORD_W     = $clog2(MESH_SIDE);
    localparam int unsigned DELTA_W     = COORD_W + 1;
    localparam int unsigned FLIT_DATA_W = 32;

    typedef enum logic [2:0] {
        DIR_LOCAL = 3'd0,
        DIR_NORTH = 3'd1,
        DIR_EAST  = 3'd2,
        DIR_SOUTH = 3'd3,
        DIR_WEST  = 3'd4
    } dir_e;

    typedef struct packed {
        logic [COORD_W-1:0]     dest_x;
        logic [COORD_W-1:0]     dest_y;
        logic [DELTA_W-1:0]     s_delta_x;
        logic [DELTA_W-1:0]     s_delta_y;
        logic [FLIT_DATA_W-1:0] data;
    } tx_flit_t;

    typedef struct packed {
        logic [DELTA_W-1:0]     s_delta_x;
        logic [DELTA_W-1:0]     s_delta_y;
        logic [FLIT_DATA_W-1:0] data;
    } rx_flit_t;

endpackage

// File: rtl/noc_node_adapter_if.sv
// Handshake bundle around the adapter: core TX/RX channels and the
// router LOCAL input/output channels.
//   slave  : the adapter side
//   master : the core + router side
interface noc_node_adapter_if #(
    parameter int unsigned DATA_W = 32
) ();

    localparam int unsigned CW = noc_node_adapter_pkg::COORD_W;
    localparam int unsigned DW = noc_node_adapter_pkg::DELTA_W;

    logic              core_tx_valid;
    logic              core_tx_ready;
    logic [CW-1:0]     core_tx_dest_x;
    logic [CW-1:0]     core_tx_dest_y;
    logic [DATA_W-1:0] core_tx_data;

    logic              core_rx_valid;
    logic              core_rx_ready;
    logic [DW-1:0]     core_rx_src_dx;
    logic [DW-1:0]     core_rx_src_dy;
    logic [DATA_W-1:0] core_rx_data;

    logic              net_out_valid;
    logic              net_out_ready;
    logic [CW-1:0]     net_out_dest_x;
    logic [CW-1:0]     net_out_dest_y;
    logic [DW-1:0]     net_out_s_delta_x;
    logic [DW-1:0]     net_out_s_delta_y;
    logic [DATA_W-1:0] net_out_data;

    logic              net_in_valid;
    logic              net_in_ready;
    logic [CW-1:0]     net_in_dest_x;
    logic [CW-1:0]     net_in_dest_y;
    logic [DW-1:0]     net_in_s_delta_x;
    logic [DW-1:0]     net_in_s_delta_y;
    logic [DATA_W-1:0] net_in_data;

    modport slave (
        input  core_tx_valid, core_tx_dest_x, core_tx_dest_y, core_tx_data,
        output core_tx_ready,
        output core_rx_valid, core_rx_src_dx, core_rx_src_dy, core_rx_data,
        input  core_rx_ready,
        output net_out_valid, net_out_dest_x, net_out_dest_y,
               net_out_s_delta_x, net_out_s_delta_y, net_out_data,
        input  net_out_ready,
        input  net_in_valid, net_in_dest_x, net_in_dest_y,
               net_in_s_delta_x, net_in_s_delta_y, net_in_data,
        output net_in_ready
    );

    modport master (
        output core_tx_valid, core_tx_dest_x, core_tx_dest_y, core_tx_data,
        input  core_tx_ready,
        input  core_rx_valid, core_rx_src_dx, core_rx_src_dy, core_rx_data,
        output core_rx_ready,
        input  net_out_valid, net_out_dest_x, net_out_dest_y,
               net_out_s_delta_x, net_out_s_delta_y, net_out_data,
        output net_out_ready,
        output net_in_valid, net_in_dest_x, net_in_dest_y,
               net_in_s_delta_x, net_in_s_delta_y, net_in_data,
        input  net_in_ready
    );

endinterface

// File: rtl/noc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst (async, active-low)
//   push/din : write side (ignored while full, even with a same-cycle pop)
//   pop/dout : read side, dout always shows the head entry
//   full, empty : status from the registered pointers
module noc_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Extra MSB on each pointer separates full from empty when indices match.
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/noc_node_adapter.sv
// Endpoint adapter on a router LOCAL port.
//   clk, rst (async, active-low)
//   bus          : core TX/RX and net in/out handshake channels (slave side)
//   misroute_err : sticky, a flit arrived for another node
//   tx_cnt       : flits injected into the mesh
//   rx_cnt       : flits delivered to the core
// DATA_W must equal FLIT_DATA_W, since the flit layouts are shared.
module noc_node_adapter
    import noc_node_adapter_pkg::*;
#(
    parameter int unsigned X_COORD  = 0,
    parameter int unsigned Y_COORD  = 0,
    parameter int unsigned DATA_W   = FLIT_DATA_W,
    parameter int unsigned TX_DEPTH = 4,
    parameter int unsigned RX_DEPTH = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    noc_node_adapter_if.slave bus,
    output logic             misroute_err,
    output logic [CNT_W-1:0] tx_cnt,
    output logic [CNT_W-1:0] rx_cnt
);

    localparam int unsigned TXW = 2 * COORD_W + 2 * DELTA_W + DATA_W;
    localparam int unsigned RXW = 2 * DELTA_W + DATA_W;

    tx_flit_t tx_in, tx_head;
    rx_flit_t rx_in, rx_head;
    logic     tx_full, tx_empty, rx_full, rx_empty;
    logic     rdy_en;
    logic     tx_push, tx_pop, rx_accept, rx_push, rx_pop, dest_match;

    // Holds both readies low through reset and for the first edge after it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdy_en <= 1'b0;
        else      rdy_en <= 1'b1;
    end

    assign bus.core_tx_ready = rdy_en && !tx_full;
    assign bus.net_in_ready  = rdy_en && !rx_full;

    // TX path
    assign tx_push = bus.core_tx_valid && bus.core_tx_ready;
    assign tx_pop  = bus.net_out_valid && bus.net_out_ready;

    always_comb begin
        tx_in           = '0;
        tx_in.dest_x    = bus.core_tx_dest_x;
        tx_in.dest_y    = bus.core_tx_dest_y;
        tx_in.s_delta_x = {1'b0, bus.core_tx_dest_x} - DELTA_W'(X_COORD);
        tx_in.s_delta_y = {1'b0, bus.core_tx_dest_y} - DELTA_W'(Y_COORD);
        tx_in.data      = bus.core_tx_data;
    end

    noc_sync_fifo #(.WIDTH(TXW), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (tx_in),
        .pop   (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign bus.net_out_valid     = !tx_empty;
    assign bus.net_out_dest_x    = tx_head.dest_x;
    assign bus.net_out_dest_y    = tx_head.dest_y;
    assign bus.net_out_s_delta_x = tx_head.s_delta_x;
    assign bus.net_out_s_delta_y = tx_head.s_delta_y;
    assign bus.net_out_data      = tx_head.data;

    // RX path: misrouted flits are accepted and dropped.
    assign dest_match = (bus.net_in_dest_x == COORD_W'(X_COORD)) &&
                        (bus.net_in_dest_y == COORD_W'(Y_COORD));
    assign rx_accept  = bus.net_in_valid && bus.net_in_ready;
    assign rx_push    = rx_accept && dest_match;
    assign rx_pop     = bus.core_rx_valid && bus.core_rx_ready;

    always_comb begin
        rx_in           = '0;
        rx_in.s_delta_x = bus.net_in_s_delta_x;
        rx_in.s_delta_y = bus.net_in_s_delta_y;
        rx_in.data      = bus.net_in_data;
    end

    noc_sync_fifo #(.WIDTH(RXW), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_in),
        .pop   (rx_pop),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign bus.core_rx_valid  = !rx_empty;
    assign bus.core_rx_src_dx = rx_head.s_delta_x;
    assign bus.core_rx_src_dy = rx_head.s_delta_y;
    assign bus.core_rx_data   = rx_head.data;

    // Statistics and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misroute_err <= 1'b0;
            tx_cnt       <= '0;
            rx_cnt       <= '0;
        end else begin
            if (rx_accept && !dest_match) misroute_err <= 1'b1;
            if (tx_pop) tx_cnt <= tx_cnt + 1'b1;
            if (rx_pop) rx_cnt <= rx_cnt + 1'b1;
        end
    end

endmodule

// File: doc/noc_node_adapter.md
Name: noc_node_adapter

Overview:
- Endpoint adapter at one mesh node: the other side of a router's LOCAL port.
- TX path: takes core write requests (dest_x, dest_y, data), computes the signed source deltas, buffers the flits and drives them into the mesh local input channel.
- RX path: accepts flits from the mesh local output channel, checks the destination against the node's own coordinate, buffers the flits and presents them to the core.
- One instance per mesh node, instantiated beside the mesh top.

Parameters:
- X_COORD, 0: node column, 0..MESH_SIDE-1.
- Y_COORD, 0: node row, 0..MESH_SIDE-1.
- MESH_SIDE, 4: mesh side length; taken from the shared package.
- DATA_W, 32: payload width.
- TX_DEPTH, 4: TX FIFO depth; power of two, ≥2.
- RX_DEPTH, 4: RX FIFO depth; power of two, ≥2.
- CNT_W, 16: statistics counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- core_tx_valid  in  1  core request valid.
- core_tx_ready  out  1  adapter can accept a request.
- core_tx_dest_x  in  COORD_W  destination column.
- core_tx_dest_y  in  COORD_W  destination row.
- core_tx_data  in  DATA_W  payload.
- core_rx_valid  out  1  received flit available.
- core_rx_ready  in  1  core consumes the flit.
- core_rx_src_dx  out  COORD_W+1  signed s_delta_x of the received flit.
- core_rx_src_dy  out  COORD_W+1  signed s_delta_y of the received flit.
- core_rx_data  out  DATA_W  received payload.
- net_out_valid / net_out_ready  out / in  1 / 1  to router LOCAL input.
- net_out_dest_x, net_out_dest_y  out  COORD_W  destination coordinate.
- net_out_s_delta_x, net_out_s_delta_y  out  COORD_W+1  signed deltas.
- net_out_data  out  DATA_W  payload.
- net_in_valid / net_in_ready  in / out  1 / 1  from router LOCAL output.
- net_in_dest_x, net_in_dest_y  in  COORD_W  destination coordinate.
- net_in_s_delta_x, net_in_s_delta_y  in  COORD_W+1  signed deltas.
- net_in_data  in  DATA_W  payload.
- misroute_err  out  1  sticky: a flit arrived with the wrong destination.
- tx_cnt  out  CNT_W  flits injected into the mesh.
- rx_cnt  out  CNT_W  flits delivered to the core.

Behaviour:
- Reset: one clock; rst asynchronous, active-low. While rst=0:
  - both FIFOs empty.
  - net_out_valid=0, core_rx_valid=0.
  - misroute_err=0, tx_cnt=0, rx_cnt=0.
  - core_tx_ready=0 and net_in_ready=0 while in reset; both go to 1 on the first clock edge after release.
- Handshake on every channel:
  - Transfer occurs when valid && ready at a rising edge.
  - Once valid is raised, it and the payload hold until the transfer.
  - No combinational path from any ready input to any valid output, or from valid to ready.
- Ready generation: core_tx_ready = !tx_full and net_in_ready = !rx_full, both registered-state-derived. A full FIFO does not accept a push even when a pop occurs in the same cycle.
- TX path:
  - On a core transfer, push {dest_x, dest_y, s_dx = dest_x - X_COORD, s_dy = dest_y - Y_COORD, data}.
  - Delta arithmetic: operands zero-extended to COORD_W+1, two's-complement result, range -(MESH_SIDE-1)..+(MESH_SIDE-1).
  - The FIFO is first-word-fall-through: net_out_valid = !tx_empty and net_out_* = head entry.
  - Latency: core transfer at edge N gives net_out_valid=1 after edge N, so the flit can be accepted at edge N+1 at the earliest.
  - A dest equal to the own coordinate is sent normally with deltas 0; the router loops it back.
- RX path:
  - On a net_in transfer, compare dest with (X_COORD, Y_COORD).
  - Match: push {s_delta_x, s_delta_y, data} into the RX FIFO.
  - Mismatch: flit consumed and discarded, misroute_err set to 1 (cleared only by reset), rx_cnt not incremented.
  - core_rx_valid = !rx_empty, outputs show the head; same 1-cycle latency as TX.
- Counters:
  - tx_cnt increments on each net_out transfer.
  - rx_cnt increments on each core_rx transfer.
  - Both wrap from 2^CNT_W-1 to 0.
- FIFO boundaries:
  - Simultaneous push and pop when non-empty and not full: occupancy unchanged.
  - Pointers wrap modulo depth, with an extra wrap bit for full/empty detection.
  - Empty FIFO: no pop is possible because valid is low.
- Reset mid-operation: all buffered flits are lost and valids drop asynchronously. The mesh side must be reset together with the adapter.

Decomposition:
- Shared package (alongside MESH_SIDE and the direction enum):
  - COORD_W = $clog2(MESH_SIDE) and DELTA_W = COORD_W+1.
  - typedef tx_flit_t {dest_x, dest_y, s_delta_x, s_delta_y, data}.
  - typedef rx_flit_t {s_delta_x, s_delta_y, data}.
- Sub-module noc_sync_fifo (params WIDTH, DEPTH; first-word fall-through; full/empty outputs; async active-low reset), instantiated twice.

Test Plan (MESH_SIDE=4, X_COORD=1, Y_COORD=2, DATA_W=32, depths 4):
- TX delta: core sends dest (3,0), data 0xCAFE0001, net_out_ready=1 → next cycle net_out_valid=1, s_delta_x=+2 (3'b010), s_delta_y=-2 (3'b110), data 0xCAFE0001; tx_cnt=1.
- TX backpressure: net_out_ready=0, core sends 5 requests → 4 accepted, core_tx_ready=0 after the 4th. Release ready → 4 flits out in order over 4 cycles; payload stable while stalled.
- RX delivery: net_in flit dest (1,2), s_delta (-1,+1), data 0x55 → core_rx_valid next cycle with src_dx=3'b111, src_dy=3'b001; after core_rx_ready, rx_cnt=1.
- Misroute: net_in flit dest (2,2) → accepted (net_in_ready=1), misroute_err=1 and stays 1, core_rx_valid stays 0, rx_cnt unchanged.
- RX full plus simultaneous pop: fill RX with 4 flits, core_rx_ready=0 → net_in_ready=0. Then a cycle with core_rx_ready=1 and net_in_valid=1 → no push that cycle, net_in_ready=1 next cycle, order preserved.
- Reset mid-traffic: assert rst low with 3 flits in TX → net_out_valid=0 immediately (no clock), counters 0, misroute_err 0; after release the FIFOs are empty.
